tlc_monitor: RTL and testbench
==============================

TLC_MONITOR -- requirements
Module: tlc_monitor

Interface
REQ-001 SHALL have parameter MIN_DWELL, default 1, minimum consecutive cycles a legal phase must be held.
REQ-002 SHALL have parameter MAX_DWELL, default 1, maximum consecutive cycles a legal phase may be held (MAX_DWELL >= MIN_DWELL >= 1).
REQ-003 SHALL have parameter CNT_W, default 8, width of err_count and cycle_count.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 en  in  1  monitor enable.
REQ-007 EW  in  3  observed East-West lamp code: 100 green, 010 yellow, 001 red.
REQ-008 NS  in  3  observed North-South lamp code, same encoding.
REQ-009 phase  out  2  last decoded legal phase (0 EWgreen, 1 EWyellow, 2 NSgreen, 3 NSyellow).
REQ-010 phase_valid  out  1  high while tracking a legal non-all-red phase.
REQ-011 err_code  out  1  one-cycle pulse: EW or NS not one-hot.
REQ-012 err_conflict  out  1  one-cycle pulse: EW and NS both one-hot and both non-red.
REQ-013 err_seq  out  1  one-cycle pulse: illegal phase transition.
REQ-014 err_dwell  out  1  one-cycle pulse: dwell-time violation.
REQ-015 err_sticky  out  1  set on any error pulse, held until reset.
REQ-016 err_count  out  CNT_W  cycles with at least one error pulse, saturating.
REQ-017 cycle_count  out  CNT_W  completed full cycles (phase 3 -> 0), wrapping.

Function
REQ-018 Sample classes SHALL be: P0 (EW=100,NS=001), P1 (010,001), P2 (001,100), P3 (001,010), ALLRED (001,001), CONFLICT, BADCODE.
REQ-019 All outputs SHALL be registered; a sample on edge N produces its flags/updates visible after edge N (one-cycle latency).
REQ-020 FSM states SHALL be SYNC, TRACK, REDHOLD.
REQ-021 SYNC: first P0-P3 -> TRACK (phase loaded, dwell=1, no seq check); ALLRED -> REDHOLD; BADCODE/CONFLICT -> stay, flag.
REQ-022 TRACK, same phase: dwell increments, saturating at MAX_DWELL+1; err_dwell pulses once when dwell first exceeds MAX_DWELL.
REQ-023 TRACK, successor phase (P0->P1->P2->P3->P0): legal; err_dwell pulses if completed dwell < MIN_DWELL; dwell reset to 1.
REQ-024 TRACK, non-successor legal phase: err_seq pulses, phase loaded, dwell=1, stay TRACK.
REQ-025 TRACK, ALLRED: legal, -> REDHOLD, phase holds, phase_valid low; MIN_DWELL check applied to departing phase.
REQ-026 REDHOLD: ALLRED stays, no dwell check; P0 or P2 -> TRACK legal; P1 or P3 -> TRACK with err_seq.
REQ-027 BADCODE or CONFLICT in any state SHALL pulse the matching flag and force SYNC; CONFLICT takes priority over BADCODE (exactly one set).
REQ-028 cycle_count SHALL increment only on a legal P3->P0 transition in TRACK; wraps at 2^CNT_W.
REQ-029 err_count SHALL increment by exactly one per cycle with any error pulse, saturating at all-ones.
REQ-030 en low SHALL force SYNC, suppress all error pulses, clear dwell, hold err_count, cycle_count, err_sticky, phase.

Reset
REQ-031 rst low at an edge SHALL set: state SYNC, phase 0, phase_valid 0, all pulse flags 0, err_sticky 0, err_count 0, cycle_count 0, dwell 0; overrides en and mid-phase tracking.

Structure
REQ-032 Package tlc_pkg SHALL hold lamp codes (GREEN, YELLOW, RED), phase enum, sample-class enum, successor-phase function; shared with tlc.
REQ-033 Combinational sub-module tlc_light_decode SHALL map (EW, NS) to sample class.

Verification
REQ-034 Defaults, drive P0,P1,P2,P3 repeated 3 cycles -> no error flags, cycle_count 2, err_count 0.
REQ-035 MIN_DWELL=2, MAX_DWELL=3, P0 x4 -> err_dwell one pulse on 4th sample; then P1 x1, P2 -> err_dwell pulse on P2 sample.
REQ-036 TRACK in P0, drive P2 -> err_seq pulse, phase=2, err_count 1; drive P3 -> no error.
REQ-037 Drive EW=100,NS=100 -> err_conflict only, state SYNC, err_sticky 1; drive EW=110 -> err_code only.
REQ-038 err_count at 255, inject error -> stays 255; rst low mid-P2 -> all outputs zero next cycle.
REQ-039 ALLRED x5 then P1 -> err_seq pulse; ALLRED then P2 -> no error, phase_valid 1.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared lamp codes, phase/sample/state enums and phase helpers for the
// traffic-light controller monitor.
package tlc_pkg;

    localparam logic [2:0] GREEN  = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] RED    = 3'b001;

    typedef enum logic [1:0] {
        PH_EWG = 2'd0,
        PH_EWY = 2'd1,
        PH_NSG = 2'd2,
        PH_NSY = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        S_P0,
        S_P1,
        S_P2,
        S_P3,
        S_ALLRED,
        S_CONFLICT,
        S_BADCODE
    } sample_t;

    typedef enum logic [1:0] {
        SYNC,
        TRACK,
        REDHOLD
    } state_t;

    function automatic phase_t next_phase(input phase_t p);
        logic [1:0] n;
        n = p + 2'd1;
        return phase_t'(n);
    endfunction

    function automatic phase_t sample_phase(input sample_t s);
        phase_t p;
        case (s)
            S_P1:    p = PH_EWY;
            S_P2:    p = PH_NSG;
            S_P3:    p = PH_NSY;
            default: p = PH_EWG;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tlc_monitor_if.sv
// Lamp observation inputs and monitor status outputs bundled as one port.
interface tlc_monitor_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic [2:0]       EW;
    logic [2:0]       NS;
    logic [1:0]       phase;
    logic             phase_valid;
    logic             err_code;
    logic             err_conflict;
    logic             err_seq;
    logic             err_dwell;
    logic             err_sticky;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output en, EW, NS,
        input  phase, phase_valid, err_code, err_conflict, err_seq, err_dwell,
               err_sticky, err_count, cycle_count
    );

    modport slave (
        input  en, EW, NS,
        output phase, phase_valid, err_code, err_conflict, err_seq, err_dwell,
               err_sticky, err_count, cycle_count
    );
endinterface

// File: rtl/tlc_light_decode.sv
// Classifies one (EW, NS) lamp observation into a sample class.
module tlc_light_decode
    import tlc_pkg::*;
(
    input  logic [2:0] EW,
    input  logic [2:0] NS,
    output sample_t    cls
);

    logic ew_ok;
    logic ns_ok;

    always_comb begin
        ew_ok = (EW == GREEN) || (EW == YELLOW) || (EW == RED);
        ns_ok = (NS == GREEN) || (NS == YELLOW) || (NS == RED);
        cls   = S_BADCODE;
        // Conflict needs both codes one-hot, so it naturally wins over BADCODE.
        if (ew_ok && ns_ok) begin
            if (EW != RED && NS != RED) cls = S_CONFLICT;
            else if (EW == GREEN)       cls = S_P0;
            else if (EW == YELLOW)      cls = S_P1;
            else if (NS == GREEN)       cls = S_P2;
            else if (NS == YELLOW)      cls = S_P3;
            else                        cls = S_ALLRED;
        end
    end

endmodule

// File: rtl/tlc_monitor.sv
// Traffic-light sequence monitor: tracks phase order and dwell times and
// reports registered error pulses, a sticky error flag and counters.
module tlc_monitor
    import tlc_pkg::*;
#(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 1,
    parameter int CNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    tlc_monitor_if.slave bus
);

    localparam int DW_W = $clog2(MAX_DWELL + 2);
    localparam logic [DW_W-1:0] MIN_D = DW_W'(MIN_DWELL);
    localparam logic [DW_W-1:0] MAX_D = DW_W'(MAX_DWELL);
    localparam logic [DW_W-1:0] ONE_D = DW_W'(1);

    sample_t          cls;
    logic             is_phase;
    phase_t           cls_ph;

    state_t           state_q, state_d;
    phase_t           phase_q, phase_d;
    logic             valid_q, valid_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             code_q, code_d;
    logic             conf_q, conf_d;
    logic             seq_q, seq_d;
    logic             dwe_q, dwe_d;
    logic             cyc_inc;
    logic             any_err;
    logic             sticky_q;
    logic [CNT_W-1:0] ecnt_q;
    logic [CNT_W-1:0] ccnt_q;

    tlc_light_decode u_decode (
        .EW  (bus.EW),
        .NS  (bus.NS),
        .cls (cls)
    );

    assign is_phase = (cls == S_P0) || (cls == S_P1) || (cls == S_P2) || (cls == S_P3);
    assign cls_ph   = sample_phase(cls);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        valid_d = valid_q;
        dwell_d = dwell_q;
        code_d  = 1'b0;
        conf_d  = 1'b0;
        seq_d   = 1'b0;
        dwe_d   = 1'b0;
        cyc_inc = 1'b0;
        if (!bus.en) begin
            state_d = SYNC;
            valid_d = 1'b0;
            dwell_d = '0;
        end else if (cls == S_CONFLICT || cls == S_BADCODE) begin
            conf_d  = (cls == S_CONFLICT);
            code_d  = (cls == S_BADCODE);
            state_d = SYNC;
            valid_d = 1'b0;
            dwell_d = '0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (is_phase) begin
                        state_d = TRACK;
                        phase_d = cls_ph;
                        valid_d = 1'b1;
                        dwell_d = ONE_D;
                    end else begin
                        state_d = REDHOLD;
                        valid_d = 1'b0;
                        dwell_d = '0;
                    end
                end
                TRACK: begin
                    if (!is_phase) begin
                        state_d = REDHOLD;
                        valid_d = 1'b0;
                        dwe_d   = (dwell_q < MIN_D);
                        dwell_d = '0;
                    end else if (cls_ph == phase_q) begin
                        // Dwell stops at MAX+1 so the overrun pulses only once.
                        if (dwell_q <= MAX_D) begin
                            dwell_d = dwell_q + ONE_D;
                            dwe_d   = (dwell_q == MAX_D);
                        end
                    end else if (cls_ph == next_phase(phase_q)) begin
                        dwe_d   = (dwell_q < MIN_D);
                        cyc_inc = (phase_q == PH_NSY);
                        phase_d = cls_ph;
                        dwell_d = ONE_D;
                    end else begin
                        seq_d   = 1'b1;
                        phase_d = cls_ph;
                        dwell_d = ONE_D;
                    end
                end
                REDHOLD: begin
                    if (is_phase) begin
                        state_d = TRACK;
                        phase_d = cls_ph;
                        valid_d = 1'b1;
                        dwell_d = ONE_D;
                        seq_d   = (cls == S_P1) || (cls == S_P3);
                    end
                end
                default: begin
                    state_d = SYNC;
                    valid_d = 1'b0;
                    dwell_d = '0;
                end
            endcase
        end
    end

    assign any_err = code_d | conf_d | seq_d | dwe_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= SYNC;
            phase_q  <= PH_EWG;
            valid_q  <= 1'b0;
            dwell_q  <= '0;
            code_q   <= 1'b0;
            conf_q   <= 1'b0;
            seq_q    <= 1'b0;
            dwe_q    <= 1'b0;
            sticky_q <= 1'b0;
            ecnt_q   <= '0;
            ccnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            dwell_q <= dwell_d;
            code_q  <= code_d;
            conf_q  <= conf_d;
            seq_q   <= seq_d;
            dwe_q   <= dwe_d;
            if (any_err) sticky_q <= 1'b1;
            if (any_err && ecnt_q != '1) ecnt_q <= ecnt_q + 1'b1;
            if (cyc_inc) ccnt_q <= ccnt_q + 1'b1;
        end
    end

    assign bus.phase        = phase_q;
    assign bus.phase_valid  = valid_q;
    assign bus.err_code     = code_q;
    assign bus.err_conflict = conf_q;
    assign bus.err_seq      = seq_q;
    assign bus.err_dwell    = dwe_q;
    assign bus.err_sticky   = sticky_q;
    assign bus.err_count    = ecnt_q;
    assign bus.cycle_count  = ccnt_q;

endmodule

// File: tb/tb_tlc_monitor.sv
// Directed self-checking bench for tlc_monitor: one default-dwell instance and
// one with MIN_DWELL=2 / MAX_DWELL=3 driven with identical lamp stimulus.
module tb_tlc_monitor;
    import tlc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passed = 0;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    tlc_monitor_if #(.CNT_W(8)) ia ();
    tlc_monitor_if #(.CNT_W(8)) ib ();

    tlc_monitor #(.MIN_DWELL(1), .MAX_DWELL(1), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    tlc_monitor #(.MIN_DWELL(2), .MAX_DWELL(3), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    always #5 clk = ~clk;

    logic [3:0] fa;
    logic [3:0] fb;
    assign fa = {ia.err_code, ia.err_conflict, ia.err_seq, ia.err_dwell};
    assign fb = {ib.err_code, ib.err_conflict, ib.err_seq, ib.err_dwell};

    task automatic drive(input logic [2:0] ew, input logic [2:0] ns);
        ia.EW = ew;
        ia.NS = ns;
        ib.EW = ew;
        ib.NS = ns;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(R, R);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(G, R);
        drive(G, R);
        checks++;
        if ({fa, ia.err_sticky, ia.phase_valid, ia.phase, ia.err_count, ia.cycle_count} !== '0)
            $display("FAIL reset_a: flags=%b sticky=%b valid=%b phase=%0d ecnt=%0d ccnt=%0d want all 0",
                     fa, ia.err_sticky, ia.phase_valid, ia.phase, ia.err_count, ia.cycle_count);
        else passed++;
        checks++;
        if ({fb, ib.err_sticky, ib.phase_valid, ib.phase, ib.err_count, ib.cycle_count} !== '0)
            $display("FAIL reset_b: flags=%b ecnt=%0d want all 0", fb, ib.err_count);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_full_cycle();
        logic [2:0] ew_seq [4];
        logic [2:0] ns_seq [4];
        ew_seq = '{G, Y, R, R};
        ns_seq = '{R, R, G, Y};
        do_reset();
        for (int rep = 0; rep < 3; rep++) begin
            for (int p = 0; p < 4; p++) begin
                drive(ew_seq[p], ns_seq[p]);
                checks++;
                if (fa !== 4'b0000 || ia.phase !== 2'(p) || ia.phase_valid !== 1'b1)
                    $display("FAIL cycle_step r%0d p%0d: flags=%b phase=%0d valid=%b want 0000/%0d/1",
                             rep, p, fa, ia.phase, ia.phase_valid, p);
                else passed++;
            end
        end
        checks++;
        if (ia.cycle_count !== 8'd2) $display("FAIL cycle_count: got %0d want 2", ia.cycle_count);
        else passed++;
        checks++;
        if (ia.err_count !== 8'd0 || ia.err_sticky !== 1'b0)
            $display("FAIL cycle_errs: ecnt=%0d sticky=%b want 0/0", ia.err_count, ia.err_sticky);
        else passed++;
    endtask

    task automatic test_dwell();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(G, R);
            checks++;
            if (fb !== ((i == 4) ? 4'b0001 : 4'b0000))
                $display("FAIL dwell_max s%0d: flags=%b want %b", i, fb, (i == 4) ? 4'b0001 : 4'b0000);
            else passed++;
        end
        drive(Y, R);
        checks++;
        if (fb !== 4'b0000) $display("FAIL dwell_p1: flags=%b want 0000", fb);
        else passed++;
        drive(R, G);
        checks++;
        if (fb !== 4'b0001 || ib.phase !== 2'd2)
            $display("FAIL dwell_min: flags=%b phase=%0d want 0001/2", fb, ib.phase);
        else passed++;
        checks++;
        if (ib.err_count !== 8'd2) $display("FAIL dwell_ecnt: got %0d want 2", ib.err_count);
        else passed++;
    endtask

    task automatic test_seq();
        do_reset();
        drive(G, R);
        drive(R, G);
        checks++;
        if (fa !== 4'b0010 || ia.phase !== 2'd2 || ia.err_count !== 8'd1)
            $display("FAIL seq_skip: flags=%b phase=%0d ecnt=%0d want 0010/2/1", fa, ia.phase, ia.err_count);
        else passed++;
        drive(R, Y);
        checks++;
        if (fa !== 4'b0000 || ia.phase !== 2'd3)
            $display("FAIL seq_after: flags=%b phase=%0d want 0000/3", fa, ia.phase);
        else passed++;
    endtask

    task automatic test_conflict();
        do_reset();
        drive(G, R);
        drive(G, G);
        checks++;
        if (fa !== 4'b0100 || ia.err_sticky !== 1'b1 || ia.phase_valid !== 1'b0)
            $display("FAIL conflict: flags=%b sticky=%b valid=%b want 0100/1/0", fa, ia.err_sticky, ia.phase_valid);
        else passed++;
        drive(Y, R);
        checks++;
        if (fa !== 4'b0000 || ia.phase !== 2'd1 || ia.phase_valid !== 1'b1)
            $display("FAIL resync: flags=%b phase=%0d valid=%b want 0000/1/1", fa, ia.phase, ia.phase_valid);
        else passed++;
        drive(3'b110, R);
        checks++;
        if (fa !== 4'b1000) $display("FAIL badcode: flags=%b want 1000", fa);
        else passed++;
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 255; i++) drive(Y, Y);
        checks++;
        if (ia.err_count !== 8'd255) $display("FAIL sat_reach: got %0d want 255", ia.err_count);
        else passed++;
        drive(3'b000, R);
        checks++;
        if (ia.err_count !== 8'd255 || fa !== 4'b1000)
            $display("FAIL sat_hold: ecnt=%0d flags=%b want 255/1000", ia.err_count, fa);
        else passed++;
        drive(G, R);
        drive(Y, R);
        drive(R, G);
        checks++;
        if (ia.phase !== 2'd2 || ia.phase_valid !== 1'b1)
            $display("FAIL pre_rst: phase=%0d valid=%b want 2/1", ia.phase, ia.phase_valid);
        else passed++;
        rst = 1'b0;
        drive(R, G);
        checks++;
        if ({fa, ia.err_sticky, ia.phase_valid, ia.phase, ia.err_count, ia.cycle_count} !== '0)
            $display("FAIL mid_rst: valid=%b phase=%0d sticky=%b ecnt=%0d want all 0",
                     ia.phase_valid, ia.phase, ia.err_sticky, ia.err_count);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_enable();
        do_reset();
        drive(G, R);
        drive(R, G);
        ia.en = 1'b0;
        ib.en = 1'b0;
        drive(G, G);
        checks++;
        if (fa !== 4'b0000 || ia.err_count !== 8'd1 || ia.phase !== 2'd2 ||
            ia.phase_valid !== 1'b0 || ia.err_sticky !== 1'b1)
            $display("FAIL en_low: flags=%b ecnt=%0d phase=%0d valid=%b sticky=%b want 0000/1/2/0/1",
                     fa, ia.err_count, ia.phase, ia.phase_valid, ia.err_sticky);
        else passed++;
        ia.en = 1'b1;
        ib.en = 1'b1;
        drive(R, Y);
        checks++;
        if (fa !== 4'b0000 || ia.phase !== 2'd3 || ia.phase_valid !== 1'b1)
            $display("FAIL en_resync: flags=%b phase=%0d valid=%b want 0000/3/1", fa, ia.phase, ia.phase_valid);
        else passed++;
    endtask

    task automatic test_redhold();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(R, R);
            checks++;
            if (fa !== 4'b0000 || ia.phase_valid !== 1'b0)
                $display("FAIL allred s%0d: flags=%b valid=%b want 0000/0", i, fa, ia.phase_valid);
            else passed++;
        end
        drive(Y, R);
        checks++;
        if (fa !== 4'b0010 || ia.phase !== 2'd1 || ia.phase_valid !== 1'b1)
            $display("FAIL red_p1: flags=%b phase=%0d valid=%b want 0010/1/1", fa, ia.phase, ia.phase_valid);
        else passed++;
        drive(R, R);
        checks++;
        if (fa !== 4'b0000 || ia.phase !== 2'd1 || ia.phase_valid !== 1'b0)
            $display("FAIL track_red: flags=%b phase=%0d valid=%b want 0000/1/0", fa, ia.phase, ia.phase_valid);
        else passed++;
        drive(R, G);
        checks++;
        if (fa !== 4'b0000 || ia.phase !== 2'd2 || ia.phase_valid !== 1'b1)
            $display("FAIL red_p2: flags=%b phase=%0d valid=%b want 0000/2/1", fa, ia.phase, ia.phase_valid);
        else passed++;
    endtask

    initial begin
        ia.en = 1'b1;
        ib.en = 1'b1;
        ia.EW = R;
        ia.NS = R;
        ib.EW = R;
        ib.NS = R;
        @(posedge clk);
        #1;
        test_reset();
        test_full_cycle();
        test_dwell();
        test_seq();
        test_conflict();
        test_saturate();
        test_enable();
        test_redhold();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
